alu_md_sequencer: RTL and testbench
===================================

// Module: alu_md_sequencer
// PURPOSE
//  Multi-cycle sequencer for the ALU's MUL and DIV operations (aluOp MULA=3'b010, DIVA=3'b011).
//  Runs an unsigned radix-2 shift-add multiply or shift-subtract divide, one bit per clock.
//  Sits beside the single-cycle ALU; decode stalls on busy and steers MUL/DIV here instead.
// PARAMETERS
//  WIDTH   32               operand/result width in bits
//  CNT_W   $clog2(WIDTH)+1  iteration counter width
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  start      in   1      request; accepted only when ready=1 and op is MULA or DIVA
//  op         in   3      aluOp encoding; sampled at accept
//  a          in   WIDTH  multiplicand / dividend; sampled at accept
//  b          in   WIDTH  multiplier / divisor; sampled at accept
//  flush      in   1      synchronous abort of any in-flight operation
//  ready      out  1      1 in IDLE only
//  busy       out  1      1 in RUN or DONE
//  done       out  1      1-cycle pulse; result, remainder and flags valid while high
//  result     out  WIDTH  MUL: low WIDTH bits of a*b; DIV: quotient a/b
//  remainder  out  WIDTH  DIV: a%b; MUL: 0
//  flags      out  2      [1]=N (result[WIDTH-1]), [0]=Z (result==0); ALU-wrapper ordering
// BEHAVIOUR
//  Reset: state=IDLE; ready=1; busy=0; done=0; result=0; remainder=0; flags=2'b00; count=0.
//  States: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: on start && (op==MULA||op==DIVA) at edge E0: latch operands, clear count -> RUN.
//         start with any other op is ignored; no state change; outputs hold.
//   RUN:  one iteration per edge, count++; after WIDTH iterations (edge E32) -> DONE.
//   DONE: done=1 for exactly one cycle; next edge -> IDLE.
//  Latency: done is visible in the cycle after E32, i.e. 33 cycles from the accept cycle.
//  Outputs update only at the RUN->DONE edge; they hold until the next completion, not cleared.
//  start while busy: ignored, not queued; the requester must hold it until ready.
//  MUL: 2*WIDTH-bit product register; upper half discarded; overflow not flagged.
//  DIV: restoring algorithm; WIDTH+1-bit partial remainder.
//  Divide by zero (b==0 at accept): IDLE->DONE at E0 without entering RUN;
//   result=all-ones, remainder=a, flags={1,0}.
//  flush: any state -> IDLE at next edge; done is suppressed; outputs keep their prior values.
//  flush and start in the same IDLE cycle: flush wins; the request is not accepted.
//  flush in DONE: done still pulses that cycle (already valid); state -> IDLE.
//  rst mid-operation: immediate return to reset values; no done.
// CONFIGURATION
//  ALU_MD_EARLY_EN defined: MUL finishes early. When the remaining multiplier bits are all 0,
//   RUN -> DONE at the next edge.
//   DIV with a<b at accept: IDLE->DONE at E0; result=0, remainder=a.
//  ALU_MD_EARLY_EN undefined: MUL/DIV always take the full 33 cycles; only divide-by-zero shortcuts.
// STRUCTURE
//  Package alu_pkg: aluOp localparams (ADDA..NOTA), md_state_t enum {IDLE,RUN,DONE},
//   flag index constants FLAG_N=1, FLAG_Z=0.
//  Sub-module md_step: combinational single iteration (shift-add or shift-sub plus restore).
//   The top level owns the FSM, counter and registers.
// TESTING
//  1 MUL a=7, b=6 -> done 33 cycles after accept; result=42, remainder=0, flags=00.
//  2 DIV a=100, b=7 -> result=14, remainder=2, flags=00.
//  3 DIV a=5, b=0 -> done the cycle after accept; result=FFFF_FFFF, remainder=5, flags=10.
//  4 MUL a=FFFF_FFFF, b=2 -> result=FFFF_FFFE, flags=10.
//    MUL a=0, b=9 -> result=0, flags=01.
//  5 flush at RUN iteration 10 of DIV -> no done; ready=1 next cycle.
//    start while busy, and start with op=ADDA -> ignored.
//    flush+start together in IDLE -> not accepted.
//  6 With ALU_MD_EARLY_EN: MUL a=3, b=1 -> done within 3 cycles.
//    DIV a=3, b=8 -> result=0, remainder=3, done the cycle after accept.
//    Without the macro: both take 33 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: aluOp encodings, flag bit positions and the MUL/DIV sequencer state type.
package alu_pkg;

    localparam logic [2:0] ADDA = 3'b000;
    localparam logic [2:0] SUBA = 3'b001;
    localparam logic [2:0] MULA = 3'b010;
    localparam logic [2:0] DIVA = 3'b011;
    localparam logic [2:0] ANDA = 3'b100;
    localparam logic [2:0] ORA  = 3'b101;
    localparam logic [2:0] XORA = 3'b110;
    localparam logic [2:0] NOTA = 3'b111;

    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } md_state_t;

    function automatic logic is_md_op(input logic [2:0] op);
        return (op == MULA) || (op == DIVA);
    endfunction

endpackage

// File: rtl/md_step.sv
// One combinational iteration of the MUL/DIV sequencer: shift-add multiply or restoring
// shift-subtract divide. The caller owns all state registers.
module md_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic [2*WIDTH-1:0] opnd_in,
    input  logic [WIDTH-1:0]   shreg_in,
    output logic [2*WIDTH-1:0] acc_out,
    output logic [2*WIDTH-1:0] opnd_out,
    output logic [WIDTH-1:0]   shreg_out
);

    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] rem_diff;
    logic           rem_ge;

    // MUL: acc accumulates the shifted multiplicand while the multiplier shifts out to the right.
    // DIV: acc[WIDTH:0] is the partial remainder; dividend bits leave shreg at the top while
    // quotient bits enter at the bottom.
    always_comb begin
        acc_out   = acc_in;
        opnd_out  = opnd_in;
        shreg_out = shreg_in;
        rem_shift = {acc_in[WIDTH-1:0], shreg_in[WIDTH-1]};
        rem_ge    = (rem_shift >= {1'b0, opnd_in[WIDTH-1:0]});
        rem_diff  = rem_shift - {1'b0, opnd_in[WIDTH-1:0]};
        if (is_div) begin
            acc_out   = {{(WIDTH-1){1'b0}}, (rem_ge ? rem_diff : rem_shift)};
            shreg_out = {shreg_in[WIDTH-2:0], rem_ge};
        end else begin
            acc_out   = acc_in + (shreg_in[0] ? opnd_in : '0);
            opnd_out  = {opnd_in[2*WIDTH-2:0], 1'b0};
            shreg_out = {1'b0, shreg_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/alu_md_sequencer.sv
// Multi-cycle unsigned MUL/DIV sequencer beside the single-cycle ALU, one bit per clock.
// Optional ALU_MD_EARLY_EN: MUL stops once the remaining multiplier bits are zero; DIV with a<b completes at accept.
module alu_md_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic [1:0]       flags
);

    md_state_t          state;
    logic               is_div_q;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] opnd_q;
    logic [WIDTH-1:0]   shreg_q;

    logic [2*WIDTH-1:0] acc_n;
    logic [2*WIDTH-1:0] opnd_n;
    logic [WIDTH-1:0]   shreg_n;

    logic               accept;
    logic               last_iter;
    logic               mul_early;
    logic [WIDTH-1:0]   fin_result;
    logic [WIDTH-1:0]   fin_rem;
    logic [1:0]         fin_flags;

    md_step #(.WIDTH(WIDTH)) u_step (
        .is_div    (is_div_q),
        .acc_in    (acc_q),
        .opnd_in   (opnd_q),
        .shreg_in  (shreg_q),
        .acc_out   (acc_n),
        .opnd_out  (opnd_n),
        .shreg_out (shreg_n)
    );

    // flush beats start, so a request in a flushed cycle is never taken.
    assign accept    = start && is_md_op(op) && !flush;
    assign last_iter = (count == CNT_W'(WIDTH - 1));

`ifdef ALU_MD_EARLY_EN
    assign mul_early = !is_div_q && (shreg_q == '0);
`else
    assign mul_early = 1'b0;
`endif

    always_comb begin
        fin_result = is_div_q ? shreg_n : acc_n[WIDTH-1:0];
        fin_rem    = is_div_q ? acc_n[WIDTH-1:0] : '0;
        fin_flags  = '0;
        fin_flags[FLAG_N] = fin_result[WIDTH-1];
        fin_flags[FLAG_Z] = (fin_result == '0);
    end

    // Result registers are written only when an operation completes and otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ready     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            remainder <= '0;
            flags     <= 2'b00;
            count     <= '0;
            is_div_q  <= 1'b0;
            acc_q     <= '0;
            opnd_q    <= '0;
            shreg_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (accept) begin
                        is_div_q <= (op == DIVA);
                        count    <= '0;
                        ready    <= 1'b0;
                        busy     <= 1'b1;
                        acc_q    <= '0;
                        if (op == DIVA && b == '0) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            result    <= '1;
                            remainder <= a;
                            flags     <= 2'b10;
                        end
`ifdef ALU_MD_EARLY_EN
                        else if (op == DIVA && a < b) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            result    <= '0;
                            remainder <= a;
                            flags     <= 2'b01;
                        end
`endif
                        else begin
                            state <= RUN;
                            if (op == DIVA) begin
                                opnd_q  <= {{WIDTH{1'b0}}, b};
                                shreg_q <= a;
                            end else begin
                                opnd_q  <= {{WIDTH{1'b0}}, a};
                                shreg_q <= b;
                            end
                        end
                    end
                end

                RUN: begin
                    if (flush) begin
                        state <= IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        acc_q   <= acc_n;
                        opnd_q  <= opnd_n;
                        shreg_q <= shreg_n;
                        count   <= count + 1'b1;
                        if (last_iter || mul_early) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            result    <= fin_result;
                            remainder <= fin_rem;
                            flags     <= fin_flags;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_md_sequencer.sv
// Randomized self-checking bench for alu_md_sequencer against an arithmetic reference model.
// Expected latencies follow ALU_MD_EARLY_EN when it is defined for the build.
module tb_alu_md_sequencer;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] remainder;
    logic [1:0]  flags;

    int checkCount = 0;
    int errCount   = 0;

    logic [31:0] lastRes;
    logic [31:0] lastRem;
    logic [1:0]  lastFlags;

    alu_md_sequencer #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .remainder (remainder),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Expected values straight from the arithmetic definition; latency counts clock edges
    // from the accept edge up to and including the edge after which done is visible.
    task automatic refModel(input logic [2:0] opc, input logic [31:0] av, input logic [31:0] bv,
                            output logic [31:0] r, output logic [31:0] rm,
                            output logic [1:0] f, output int lat);
        logic [63:0] prod;
        int bitLen;
        bitLen = 0;
        for (int i = 0; i < 32; i++)
            if (bv[i]) bitLen = i + 1;
        lat = 33;
        if (opc == MULA) begin
            prod = 64'(av) * 64'(bv);
            r    = prod[31:0];
            rm   = 32'd0;
`ifdef ALU_MD_EARLY_EN
            lat = 2 + ((bitLen < 31) ? bitLen : 31);
`endif
        end else if (bv == 32'd0) begin
            r   = 32'hFFFF_FFFF;
            rm  = av;
            lat = 1;
        end else begin
            r  = av / bv;
            rm = av % bv;
`ifdef ALU_MD_EARLY_EN
            if (av < bv) lat = 1;
`endif
        end
        f = {r[31], (r == 32'd0)};
    endtask

    task automatic applyStimulus(input logic [2:0] opc, input logic [31:0] av,
                                 input logic [31:0] bv, input bit poke);
        logic [31:0] expRes;
        logic [31:0] expRem;
        logic [1:0]  expFlags;
        int          expLat;
        int          edges;
        bit          seen;
        refModel(opc, av, bv, expRes, expRem, expFlags, expLat);
        @(negedge clk);
        start = 1'b1;
        op    = opc;
        a     = av;
        b     = bv;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            start = 1'b0;
            if (edges == 1) begin
                checkOutput("busy_after_accept", 64'(busy), 64'd1);
                checkOutput("ready_after_accept", 64'(ready), 64'd0);
                a = $urandom;
                b = $urandom;
            end
            if (poke && edges == 2 && !done) begin
                start = 1'b1;
                op    = DIVA;
                b     = $urandom_range(1, 100);
            end
            if (done) seen = 1'b1;
        end
        checkOutput("latency", 64'(edges), 64'(expLat));
        checkOutput("result", 64'(result), 64'(expRes));
        checkOutput("remainder", 64'(remainder), 64'(expRem));
        checkOutput("flags", 64'(flags), 64'(expFlags));
        @(posedge clk);
        #1;
        checkOutput("done_one_cycle", 64'(done), 64'd0);
        checkOutput("ready_back", 64'(ready), 64'd1);
        lastRes   = expRes;
        lastRem   = expRem;
        lastFlags = expFlags;
    endtask

    task automatic checkIdleHeld(input string tag);
        checkOutput({tag, "_ready"}, 64'(ready), 64'd1);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_done"}, 64'(done), 64'd0);
        checkOutput({tag, "_result"}, 64'(result), 64'(lastRes));
        checkOutput({tag, "_rem"}, 64'(remainder), 64'(lastRem));
    endtask

    initial begin
        int doneSeen;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        rst = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op = ADDA;
        a = '0;
        b = '0;
        lastRes = '0;
        lastRem = '0;
        lastFlags = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ready", 64'(ready), 64'd1);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_result", 64'(result), 64'd0);
        checkOutput("rst_rem", 64'(remainder), 64'd0);
        checkOutput("rst_flags", 64'(flags), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(MULA, 32'd7, 32'd6, 1'b1);
        applyStimulus(DIVA, 32'd100, 32'd7, 1'b0);
        applyStimulus(DIVA, 32'd5, 32'd0, 1'b0);
        applyStimulus(MULA, 32'hFFFF_FFFF, 32'd2, 1'b0);
        applyStimulus(MULA, 32'd0, 32'd9, 1'b0);
        applyStimulus(MULA, 32'd3, 32'd1, 1'b0);
        applyStimulus(DIVA, 32'd3, 32'd8, 1'b0);

        $display("[TB] non-MD op and flush+start in IDLE");
        @(negedge clk);
        start = 1'b1;
        op = ADDA;
        a = 32'd11;
        b = 32'd4;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        checkIdleHeld("adda_ignored");
        @(negedge clk);
        start = 1'b1;
        op = MULA;
        flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        checkIdleHeld("flush_start");

        $display("[TB] flush during DIV");
        @(negedge clk);
        start = 1'b1;
        op = DIVA;
        a = 32'd1000;
        b = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkIdleHeld("flush_run");
        doneSeen = 0;
        repeat (36) begin
            @(posedge clk);
            #1;
            if (done) doneSeen++;
        end
        checkOutput("flush_no_done", 64'(doneSeen), 64'd0);

        $display("[TB] reset mid-operation");
        @(negedge clk);
        start = 1'b1;
        op = MULA;
        a = 32'd12345;
        b = 32'hF000_0001;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        lastRes = '0;
        lastRem = '0;
        checkIdleHeld("mid_reset");
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] randomized operations");
        for (int n = 0; n < 24; n++) begin
            rop = ($urandom_range(0, 1) == 0) ? MULA : DIVA;
            ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom);
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = ra + 32'($urandom_range(1, 1000));
                default: rb = 32'($urandom);
            endcase
            applyStimulus(rop, ra, rb, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errCount);
        $finish;
    end

endmodule
